uart_tx_buffer: RTL and testbench

Byte FIFO between the CPU's memory-mapped UART write path and the UART transmitter. CPU stores are queued without stalling. A drain state machine presents one byte at a time on `tx_data`/`send` and holds the request until the transmitter, which runs on the slow baud clock, acknowledges by going busy. It then waits for the transmitter to return idle before launching the next byte.

---
 rtl/uart_tx_buffer_pkg.sv | 14 +
 rtl/uart_tx_buffer_if.sv | 31 +++
 rtl/uart_tx_buffer_sync_2ff.sv | 27 ++
 rtl/uart_tx_buffer.sv | 112 +++++++++++
 tb/tb_uart_tx_buffer.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_buffer_pkg.sv
// Shared UART definitions used by the transmit buffer and its synchronizer.
//   UART_DW     : byte width on the UART data path
//   txb_state_t : drain state machine states of the transmit buffer
package uart_pkg;

    localparam int unsigned UART_DW = 8;

    typedef enum logic [1:0] {
        TXB_IDLE,
        TXB_REQ,
        TXB_WAIT
    } txb_state_t;

endpackage

// File: rtl/uart_tx_buffer_if.sv
// Bus bundle between the CPU write path / UART transmitter and uart_tx_buffer.
//   master : CPU + transmitter side (drives wr_en, wr_data, clr_overflow, uart_free)
//   slave  : buffer side (drives send, tx_data, full, empty, count, overflow, busy)
interface uart_tx_buffer_if
    import uart_pkg::*;
#(
    parameter int unsigned AW = 3
);
    logic               wr_en;
    logic [UART_DW-1:0] wr_data;
    logic               clr_overflow;
    logic               uart_free;
    logic               send;
    logic [UART_DW-1:0] tx_data;
    logic               full;
    logic               empty;
    logic [AW:0]        count;
    logic               overflow;
    logic               busy;

    modport master (
        output wr_en, wr_data, clr_overflow, uart_free,
        input  send, tx_data, full, empty, count, overflow, busy
    );

    modport slave (
        input  wr_en, wr_data, clr_overflow, uart_free,
        output send, tx_data, full, empty, count, overflow, busy
    );

endinterface

// File: rtl/uart_tx_buffer_sync_2ff.sv
// One-bit two-flop synchronizer, asynchronous active-high reset to 0.
//   clk : destination clock
//   rst : asynchronous active-high reset
//   i_d : asynchronous input
//   o_q : synchronized output
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte FIFO between the CPU UART write path and the baud-clock transmitter.
// CPU stores are queued without stalling; a drain FSM presents one byte on
// tx_data/send, holds it until the transmitter goes busy, then waits for it
// to return idle before launching the next byte.
//   clk_50m : system clock
//   reset   : asynchronous active-high reset
//   bus     : slave side of uart_tx_buffer_if (write strobe/data, overflow
//             clear, uart_free in; send, tx_data, full, empty, count,
//             overflow, busy out)
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic             clk_50m,
    input  logic             reset,
    uart_tx_buffer_if.slave  bus
);
    logic [UART_DW-1:0] r_mem [DEPTH];
    logic [AW-1:0]      r_wp;
    logic [AW-1:0]      r_rp;
    logic [AW:0]        r_count;
    logic               r_overflow;
    logic [UART_DW-1:0] r_tx_data;
    txb_state_t         r_state;
    txb_state_t         w_state_nxt;

    logic w_free_s;
    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_drop;

    sync_2ff u_sync_free (
        .clk (clk_50m),
        .rst (reset),
        .i_d (bus.uart_free),
        .o_q (w_free_s)
    );

    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_empty = (r_count == '0);

    // A pop in the same cycle frees a slot, so a write while full still lands.
    assign w_push = bus.wr_en && (!w_full || w_pop);
    assign w_drop = bus.wr_en && !w_push;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            TXB_IDLE: begin
                if (!w_empty && w_free_s) begin
                    w_pop       = 1'b1;
                    w_state_nxt = TXB_REQ;
                end
            end
            TXB_REQ: begin
                if (!w_free_s) w_state_nxt = TXB_WAIT;
            end
            TXB_WAIT: begin
                if (w_free_s) w_state_nxt = TXB_IDLE;
            end
            default: w_state_nxt = TXB_IDLE;
        endcase
    end

    always_ff @(posedge clk_50m or posedge reset) begin
        if (reset) r_state <= TXB_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Storage carries no reset; reset discards the queue through the pointers.
    always_ff @(posedge clk_50m) begin
        if (w_push) r_mem[r_wp] <= bus.wr_data;
    end

    always_ff @(posedge clk_50m or posedge reset) begin
        if (reset) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop) begin
                r_rp      <= r_rp + AW'(1);
                r_tx_data <= r_mem[r_rp];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            // Set has priority over clear.
            if (w_drop)                r_overflow <= 1'b1;
            else if (bus.clr_overflow) r_overflow <= 1'b0;
        end
    end

    assign bus.send     = (r_state == TXB_REQ);
    assign bus.tx_data  = r_tx_data;
    assign bus.full     = w_full;
    assign bus.empty    = w_empty;
    assign bus.count    = r_count;
    assign bus.overflow = r_overflow;
    assign bus.busy     = (r_state != TXB_IDLE);

endmodule

// File: tb/tb_uart_tx_buffer.sv
module tb_uart_tx_buffer;
    import uart_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;

    logic clk_50m = 1'b0;
    logic reset   = 1'b1;

    uart_tx_buffer_if #(.AW(AW)) bus ();

    uart_tx_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_50m (clk_50m),
        .reset   (reset),
        .bus     (bus)
    );

    always #10 clk_50m = ~clk_50m;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_50m);
        #1;
    endtask

    // Reference model: bytes queued but not yet launched, occupancy, and a
    // transmitter that answers each send with random accept/idle delays.
    logic [7:0]  q_exp[$];
    int          m_cnt;
    logic        m_prev_send;
    logic [7:0]  m_last;
    int          m_phase;
    int unsigned m_delay;

    task automatic traffic_cycle(input bit allow_wr);
        bit   pushed;
        logic rose;
        pushed           = 1'b0;
        bus.wr_en        = 1'b0;
        bus.clr_overflow = 1'b0;
        if (allow_wr && m_cnt < int'(DEPTH) && $urandom_range(2, 0) == 0) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'($urandom);
            q_exp.push_back(bus.wr_data);
            pushed = 1'b1;
        end
        if (m_phase == 1) begin
            if (m_delay == 0) begin bus.uart_free = 1'b0; m_phase = 2; end
            else m_delay--;
        end else if (m_phase == 3) begin
            if (m_delay == 0) begin bus.uart_free = 1'b1; m_phase = 0; end
            else m_delay--;
        end
        tick();
        bus.wr_en   = 1'b0;
        rose        = bus.send && !m_prev_send;
        m_prev_send = bus.send;
        m_cnt       = m_cnt + (pushed ? 1 : 0) - (rose ? 1 : 0);
        check("rnd count", 32'(bus.count), 32'(m_cnt));
        check("rnd full", 32'(bus.full), 32'(m_cnt == int'(DEPTH)));
        check("rnd empty", 32'(bus.empty), 32'(m_cnt == 0));
        check("rnd overflow", 32'(bus.overflow), 32'(0));
        check("send while uart busy", 32'(rose && m_phase != 0), 32'(0));
        if (rose) begin
            if (q_exp.size() == 0) begin
                check("spurious send", 32'(1), 32'(0));
            end else begin
                check("tx order", 32'(bus.tx_data), 32'(q_exp.pop_front()));
            end
            m_last  = bus.tx_data;
            m_phase = 1;
            m_delay = $urandom_range(4, 0);
        end else if (bus.send) begin
            check("tx_data hold", 32'(bus.tx_data), 32'(m_last));
        end
        if (m_phase == 2 && !bus.send) begin
            m_phase = 3;
            m_delay = $urandom_range(4, 0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bit seen_send;
        bus.wr_en        = 1'b0;
        bus.wr_data      = '0;
        bus.clr_overflow = 1'b0;
        bus.uart_free    = 1'b1;

        // Reset state
        tick(); tick();
        check("rst send", 32'(bus.send), 32'(0));
        check("rst tx_data", 32'(bus.tx_data), 32'(8'h00));
        check("rst full", 32'(bus.full), 32'(0));
        check("rst empty", 32'(bus.empty), 32'(1));
        check("rst count", 32'(bus.count), 32'(0));
        check("rst overflow", 32'(bus.overflow), 32'(0));
        check("rst busy", 32'(bus.busy), 32'(0));
        reset = 1'b0;

        // Idle with no writes
        seen_send = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.send) seen_send = 1'b1;
        end
        check("idle send", 32'(seen_send), 32'(0));
        check("idle empty", 32'(bus.empty), 32'(1));
        check("idle count", 32'(bus.count), 32'(0));

        // Single byte: launch latency and handshake
        bus.wr_en = 1'b1; bus.wr_data = 8'hA5;
        tick();
        bus.wr_en = 1'b0;
        check("a5 send e1", 32'(bus.send), 32'(0));
        check("a5 count e1", 32'(bus.count), 32'(1));
        tick();
        check("a5 send e2", 32'(bus.send), 32'(1));
        check("a5 tx_data", 32'(bus.tx_data), 32'(8'hA5));
        check("a5 busy", 32'(bus.busy), 32'(1));
        check("a5 count e2", 32'(bus.count), 32'(0));
        for (int i = 0; i < 4; i++) tick();
        check("a5 send held", 32'(bus.send), 32'(1));
        bus.uart_free = 1'b0;
        tick(); tick();
        check("a5 send 2 after drop", 32'(bus.send), 32'(1));
        tick();
        check("a5 send fall", 32'(bus.send), 32'(0));
        check("a5 busy wait", 32'(bus.busy), 32'(1));
        bus.uart_free = 1'b1;
        tick(); tick();
        check("a5 busy before idle", 32'(bus.busy), 32'(1));
        tick();
        check("a5 busy clear", 32'(bus.busy), 32'(0));

        // Fill while the transmitter is busy, then overflow
        bus.uart_free = 1'b0;
        tick(); tick(); tick();
        for (int i = 1; i <= 8; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'(i);
            tick();
        end
        bus.wr_en = 1'b0;
        check("fill full", 32'(bus.full), 32'(1));
        check("fill count", 32'(bus.count), 32'(8));
        check("fill empty", 32'(bus.empty), 32'(0));
        check("fill send", 32'(bus.send), 32'(0));
        bus.wr_en = 1'b1; bus.wr_data = 8'h09;
        tick();
        bus.wr_en = 1'b0;
        check("ovf set", 32'(bus.overflow), 32'(1));
        check("ovf count", 32'(bus.count), 32'(8));
        bus.wr_en = 1'b1; bus.wr_data = 8'h0A; bus.clr_overflow = 1'b1;
        tick();
        bus.wr_en = 1'b0;
        check("ovf set beats clr", 32'(bus.overflow), 32'(1));
        tick();
        bus.clr_overflow = 1'b0;
        check("ovf clr", 32'(bus.overflow), 32'(0));
        check("ovf clr count", 32'(bus.count), 32'(8));

        // Write while full in the same cycle as the first pop
        bus.uart_free = 1'b1;
        tick(); tick();
        check("pre-pop send", 32'(bus.send), 32'(0));
        bus.wr_en = 1'b1; bus.wr_data = 8'h55;
        tick();
        bus.wr_en = 1'b0;
        check("push+pop count", 32'(bus.count), 32'(8));
        check("push+pop overflow", 32'(bus.overflow), 32'(0));
        check("push+pop send", 32'(bus.send), 32'(1));
        check("push+pop tx_data", 32'(bus.tx_data), 32'(8'h01));

        // Drain in order under random traffic with the transmitter model
        q_exp.delete();
        for (int i = 2; i <= 8; i++) q_exp.push_back(8'(i));
        q_exp.push_back(8'h55);
        m_cnt = 8; m_prev_send = 1'b1; m_last = 8'h01; m_phase = 1; m_delay = 2;
        for (int i = 0; i < 600; i++) traffic_cycle(1'b1);
        for (int i = 0; i < 3000; i++) begin
            if (q_exp.size() == 0 && m_phase == 0 && !bus.busy) break;
            traffic_cycle(1'b0);
        end
        check("drain queue left", 32'(q_exp.size()), 32'(0));
        check("drain busy", 32'(bus.busy), 32'(0));
        check("drain empty", 32'(bus.empty), 32'(1));

        // Reset during REQ with 3 bytes queued
        bus.uart_free = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'(8'hB0 + i);
            tick();
        end
        bus.wr_en = 1'b0;
        check("pre-rst send", 32'(bus.send), 32'(1));
        check("pre-rst count", 32'(bus.count), 32'(3));
        check("pre-rst tx_data", 32'(bus.tx_data), 32'(8'hB0));
        #2;
        reset = 1'b1;
        #1;
        check("mid rst send", 32'(bus.send), 32'(0));
        check("mid rst count", 32'(bus.count), 32'(0));
        check("mid rst empty", 32'(bus.empty), 32'(1));
        check("mid rst busy", 32'(bus.busy), 32'(0));
        tick(); tick();
        reset = 1'b0;
        bus.wr_en = 1'b1; bus.wr_data = 8'h3C;
        tick();
        bus.wr_en = 1'b0;
        check("3c send e1", 32'(bus.send), 32'(0));
        check("3c count e1", 32'(bus.count), 32'(1));
        tick();
        check("3c send e2", 32'(bus.send), 32'(0));
        tick();
        check("3c send e3", 32'(bus.send), 32'(1));
        check("3c tx_data", 32'(bus.tx_data), 32'(8'h3C));
        bus.uart_free = 1'b0;
        tick(); tick(); tick();
        check("3c send fall", 32'(bus.send), 32'(0));
        bus.uart_free = 1'b1;
        tick(); tick(); tick();
        check("3c busy clear", 32'(bus.busy), 32'(0));
        check("3c empty", 32'(bus.empty), 32'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
